// File: rtl/tone_pkg.sv
// tone_pkg: shared constants and types for the tone PWM generator.
// Rest threshold, octave-1 base period table, FSM state type.
package tone_pkg;

  localparam logic [3:0] NOTE_REST_MIN = 4'd12;

  // Table below is exact at this clock; other clocks are rescaled.
  localparam longint unsigned REF_HZ = 64'd100_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tone_state_e;

  // Octave-1 periods: round(REF_HZ / f), f = 440*2^((n-45)/12).
  function automatic longint unsigned base_at_ref(
    input int unsigned note
  );
    case (note)
      0:       return 64'd3_057_805;
      1:       return 64'd2_886_184;
      2:       return 64'd2_724_195;
      3:       return 64'd2_571_297;
      4:       return 64'd2_426_982;
      5:       return 64'd2_290_766;
      6:       return 64'd2_162_195;
      7:       return 64'd2_040_840;
      8:       return 64'd1_926_297;
      9:       return 64'd1_818_182;
      10:      return 64'd1_716_135;
      11:      return 64'd1_619_816;
      default: return 64'd0;
    endcase
  endfunction

  // Rounded rescale of the reference table to clk_hz.
  function automatic longint unsigned base_period(
    input longint unsigned clk_hz,
    input int unsigned     note
  );
    return (base_at_ref(note) * clk_hz + REF_HZ / 2) / REF_HZ;
  endfunction

endpackage

// File: rtl/tone_period_lut.sv
// tone_period_lut: note code + octave shift -> tone period in clocks.
// Ports: note (0..11 tone, 12..15 rest -> 0), h (octave-1), period.
module tone_period_lut
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 22
) (
  input  logic [3:0]       note,
  input  logic [2:0]       h,
  output logic [CNT_W-1:0] period
);

  logic [CNT_W-1:0] tbl [16];

  // Constant entries; rest codes fall to the zero default.
  for (genvar i = 0; i < 16; i++) begin : g_tbl
    assign tbl[i] = CNT_W'(base_period(64'(CLK_HZ), i));
  end

  assign period = tbl[note] >> h;

endmodule

// File: rtl/tone_pwm_gen.sv
// tone_pwm_gen: note/octave/duty -> glitch-free square-wave PWM drive.
// Ports: clk, rst_n, freq, h, duty in; PWM, tone_on, wrap out.
module tone_pwm_gen
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = 22,
  parameter int unsigned DUTY_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        freq,
  input  logic [2:0]        h,
  input  logic [DUTY_W-1:0] duty,
  output logic              PWM,
  output logic              tone_on,
  output logic              wrap
);

  localparam int unsigned PW = CNT_W + DUTY_W;

  logic [3:0]        freq_q;
  logic [2:0]        h_q;
  logic [DUTY_W-1:0] duty_q;

  logic [CNT_W-1:0]  lut_period;
  logic [PW-1:0]     prod;
  logic [CNT_W-1:0]  pend_period_d, pend_period_q;
  logic [CNT_W-1:0]  pend_thresh_d, pend_thresh_q;
  logic              pend_rest_d, pend_rest_q;

  tone_state_e       state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [CNT_W-1:0]  cur_period_d, cur_period_q;
  logic [CNT_W-1:0]  cur_thresh_d, cur_thresh_q;
  logic              pwm_d, pwm_q;
  logic              tone_on_d, tone_on_q;
  logic              wrap_d, wrap_q;
  logic              last;

  tone_period_lut #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (CNT_W)
  ) u_lut (
    .note   (freq_q),
    .h      (h_q),
    .period (lut_period)
  );

  always_comb begin
    prod = {{DUTY_W{1'b0}}, lut_period}
         * {{CNT_W{1'b0}}, duty_q};
    pend_period_d = lut_period;
    pend_thresh_d = prod[PW-1:DUTY_W];
    pend_rest_d   = (freq_q >= NOTE_REST_MIN);
  end

  always_comb begin
    last         = (cnt_q == cur_period_q - CNT_W'(1));
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_period_d = cur_period_q;
    cur_thresh_d = cur_thresh_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!pend_rest_q) begin
          state_d      = RUN;
          cur_period_d = pend_period_q;
          cur_thresh_d = pend_thresh_q;
        end
      end
      RUN: begin
        // Rest overrides everything; pitch only swaps at the boundary.
        if (pend_rest_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          cnt_d        = '0;
          cur_period_d = pend_period_q;
          cur_thresh_d = pend_thresh_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs registered against the next count so they line up with it.
    tone_on_d = (state_d == RUN);
    pwm_d     = tone_on_d && (cnt_d < cur_thresh_d);
    wrap_d    = tone_on_d
             && (cnt_d == cur_period_d - CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q        <= NOTE_REST_MIN;
      h_q           <= '0;
      duty_q        <= '0;
      pend_period_q <= '0;
      pend_thresh_q <= '0;
      pend_rest_q   <= 1'b1;
    end else begin
      freq_q        <= freq;
      h_q           <= h;
      duty_q        <= duty;
      pend_period_q <= pend_period_d;
      pend_thresh_q <= pend_thresh_d;
      pend_rest_q   <= pend_rest_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_period_q <= '0;
      cur_thresh_q <= '0;
      pwm_q        <= 1'b0;
      tone_on_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_period_q <= cur_period_d;
      cur_thresh_q <= cur_thresh_d;
      pwm_q        <= pwm_d;
      tone_on_q    <= tone_on_d;
      wrap_q       <= wrap_d;
    end
  end

  assign PWM     = pwm_q;
  assign tone_on = tone_on_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_tone_pwm_gen.sv
// tb_tone_pwm_gen: self-checking bench for tone_pwm_gen.
// Scaled clock keeps periods short; reference model uses the pitch formula.
module tb_tone_pwm_gen;

  localparam int unsigned CLK_HZ = 100_000;
  localparam int GUARD = 8000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] freq;
  logic [2:0] h;
  logic [9:0] duty;
  logic       pwm, tone_on, wrap;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] f;
    logic [2:0] h;
    logic [9:0] d;
    int         per;
    int         hi;
  } vec_t;

  vec_t vecs[$];

  tone_pwm_gen #(
    .CLK_HZ (CLK_HZ),
    .CNT_W  (22),
    .DUTY_W (10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .freq    (freq),
    .h       (h),
    .duty    (duty),
    .PWM     (pwm),
    .tone_on (tone_on),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  function automatic int model_period(int n, int hh);
    real f;
    int  base;
    f = 440.0 * $pow(2.0, (real'(n) - 45.0) / 12.0);
    base = $rtoi(real'(CLK_HZ) / f + 0.5);
    return base >> hh;
  endfunction

  function automatic int model_high(int p, int d);
    longint x;
    x = (longint'(p) * longint'(d)) >> 10;
    return int'(x);
  endfunction

  function automatic vec_t mkvec(int f, int hh, int d);
    vec_t v;
    v.f   = 4'(f);
    v.h   = 3'(hh);
    v.d   = 10'(d);
    v.per = model_period(f, hh);
    v.hi  = model_high(v.per, d);
    return v;
  endfunction

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(int f, int hh, int d);
    freq = 4'(f);
    h    = 3'(hh);
    duty = 10'(d);
  endtask

  // Sync to a wrap, then count one whole period and its high cycles.
  task automatic measure(output int per, output int hi, output bit ok);
    int g;
    per = 0;
    hi  = 0;
    ok  = 1'b1;
    g   = 0;
    while (!wrap && g < GUARD) begin
      step();
      g++;
    end
    if (!wrap) begin
      ok = 1'b0;
      return;
    end
    do begin
      step();
      per++;
      if (pwm) hi++;
    end while (!wrap && per < GUARD);
    if (!wrap) ok = 1'b0;
  endtask

  initial begin
    int  per, hi, run, errs;
    bit  ok;
    vec_t v;

    rst_n = 1'b0;
    apply(12, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("reset_pwm", pwm, 0);
    check("reset_tone_on", tone_on, 0);
    check("reset_wrap", wrap, 0);

    // Start latency and first high run (A4).
    apply(9, 3, 512);
    step();
    step();
    check("start_n2_pwm", pwm, 0);
    step();
    check("start_n3_pwm", pwm, 1);
    check("start_n3_tone_on", tone_on, 1);
    run = 1;
    step();
    while (pwm && run < GUARD) begin
      run++;
      step();
    end
    check("start_high_run", run, model_high(model_period(9, 3), 512));

    // Pitch change mid-period: old period must finish intact.
    measure(per, hi, ok);
    check("pitch_sync_ok", ok, 1);
    per = 0;
    hi  = 0;
    do begin
      step();
      per++;
      if (pwm) hi++;
      if (per == 100) apply(0, 3, 512);
    end while (!wrap && per < GUARD);
    check("pitch_old_per", per, model_period(9, 3));
    check("pitch_old_hi", hi, model_high(model_period(9, 3), 512));
    measure(per, hi, ok);
    check("pitch_new_ok", ok, 1);
    check("pitch_new_per", per, model_period(0, 3));
    check("pitch_new_hi", hi, model_high(model_period(0, 3), 512));

    // Mute right after a wrap, while PWM is high.
    apply(12, 3, 512);
    step();
    step();
    check("mute_hold_pwm", pwm, 1);
    step();
    check("mute_pwm", pwm, 0);
    check("mute_tone_on", tone_on, 0);
    errs = 0;
    repeat (30) begin
      step();
      if (pwm || tone_on || wrap) errs++;
    end
    check("mute_quiet", errs, 0);

    // Table: octave sweep, duty edges, a few notes.
    for (int i = 0; i < 8; i++) vecs.push_back(mkvec(9, i, 512));
    vecs.push_back(mkvec(0, 3, 0));
    vecs.push_back(mkvec(0, 3, 1023));
    vecs.push_back(mkvec(11, 4, 300));
    vecs.push_back(mkvec(5, 2, 1));
    foreach (vecs[i]) begin
      v = vecs[i];
      apply(int'(v.f), int'(v.h), int'(v.d));
      repeat (3) step();
      measure(per, hi, ok);
      check($sformatf("vec%0d_ok", i), ok, 1);
      check($sformatf("vec%0d_per", i), per, v.per);
      check($sformatf("vec%0d_hi", i), hi, v.hi);
    end

    // Randomized notes against the model.
    for (int i = 0; i < 15; i++) begin
      v = mkvec(int'($urandom_range(0, 11)),
                int'($urandom_range(2, 7)),
                int'($urandom_range(0, 1023)));
      apply(int'(v.f), int'(v.h), int'(v.d));
      repeat (3) step();
      measure(per, hi, ok);
      check($sformatf("rnd%0d_per", i), per, v.per);
      check($sformatf("rnd%0d_hi", i), hi, v.hi);
    end

    // Asynchronous reset while the tone is high.
    apply(9, 3, 512);
    repeat (3) step();
    measure(per, hi, ok);
    step();
    step();
    check("arst_pre_pwm", pwm, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pwm", pwm, 0);
    check("arst_tone_on", tone_on, 0);
    check("arst_wrap", wrap, 0);
    apply(12, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (20) begin
      step();
      if (pwm || tone_on || wrap) errs++;
    end
    check("arst_quiet", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
